// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arb_pkg;

    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } owner_t;

    localparam int STAT_W = 16;
    localparam int RD_LAT = 2;

    // Saturating increment used by the per-requester transfer counters
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last,
    output logic [1:0] o_gnt
);

    // Lone requester always wins; on contention the one not served last wins
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_last == OWN1) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin sequencer for a single-port memory (optional MEM_ARB_STATS_EN)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [N-1:0]      addr0,
    input  logic [N-1:0]      wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [N-1:0]      addr1,
    input  logic [N-1:0]      wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [N-1:0]      rdata0,
    output logic [N-1:0]      rdata1,
    output logic              mem_we,
    output logic [N-1:0]      mem_addr,
    output logic [N-1:0]      mem_write,
`ifdef MEM_ARB_STATS_EN
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_cnt0,
    output logic [STAT_W-1:0] stat_cnt1,
`endif
    input  logic [N-1:0]      mem_read
);

    owner_t       r_last;
    logic [1:0]   w_gnt;
    logic         w_xfer;
    logic         w_sel1;
    logic         w_we;
    logic [N-1:0] w_addr;
    logic [N-1:0] w_wdata;

    logic         r_mem_we;
    logic [N-1:0] r_mem_addr;
    logic [N-1:0] r_mem_write;
    logic         r_s1_valid;
    owner_t       r_s1_owner;
    logic         r_s1_rd;
    logic         r_s2_valid;
    owner_t       r_s2_owner;

    rr_arb2 u_rr_arb2 (
        .i_req  ({req1, req0}),
        .i_last (r_last),
        .o_gnt  (w_gnt)
    );

    // A grant is only ever issued to an active requester, so any grant is a transfer
    assign gnt0    = w_gnt[0];
    assign gnt1    = w_gnt[1];
    assign w_xfer  = |w_gnt;
    assign w_sel1  = w_gnt[1];
    assign w_we    = w_sel1 ? we1    : we0;
    assign w_addr  = w_sel1 ? addr1  : addr0;
    assign w_wdata = w_sel1 ? wdata1 : wdata0;

    // Round-robin pointer: remembers who was served on the latest transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= OWN1;
        end else if (w_xfer) begin
            r_last <= w_sel1 ? OWN1 : OWN0;
        end
    end

    // Issue stage: drive the memory port; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_write <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_owner  <= OWN0;
            r_s1_rd     <= 1'b0;
        end else if (w_xfer) begin
            r_mem_we    <= w_we;
            r_mem_addr  <= w_addr;
            r_mem_write <= w_wdata;
            r_s1_valid  <= 1'b1;
            r_s1_owner  <= w_sel1 ? OWN1 : OWN0;
            r_s1_rd     <= ~w_we;
        end else begin
            r_mem_we    <= 1'b0;
            r_s1_valid  <= 1'b0;
        end
    end

    // Response tag stage: lines up with the memory's registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_owner <= OWN0;
        end else begin
            r_s2_valid <= r_s1_valid & r_s1_rd;
            r_s2_owner <= r_s1_owner;
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_write = r_mem_write;
    assign rvalid0   = r_s2_valid && (r_s2_owner == OWN0);
    assign rvalid1   = r_s2_valid && (r_s2_owner == OWN1);
    assign rdata0    = mem_read;
    assign rdata1    = mem_read;

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_cnt0;
    logic [STAT_W-1:0] r_stat_cnt1;

    // Saturating per-requester transfer counters; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_cnt0 <= '0;
            r_stat_cnt1 <= '0;
        end else if (stat_clr) begin
            r_stat_cnt0 <= '0;
            r_stat_cnt1 <= '0;
        end else begin
            if (w_gnt[0]) r_stat_cnt0 <= sat_inc(r_stat_cnt0);
            if (w_gnt[1]) r_stat_cnt1 <= sat_inc(r_stat_cnt1);
        end
    end

    assign stat_cnt0 = r_stat_cnt0;
    assign stat_cnt1 = r_stat_cnt1;
`endif

endmodule
